qpsk_symbol_mapper: RTL and testbench
=====================================

QPSK_SYMBOL_MAPPER -- requirements
Module: qpsk_symbol_mapper

Interface
REQ-001 Parameter SPS, default 4, samples (clock cycles) per symbol; legal range 4..255.
REQ-002 Parameter AMP, default 8'sd90, signed 8-bit per-rail amplitude; legal range 1..127.
REQ-003 CLK  input  1  clock; all state updates on the rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  mapper enable; when low, no FIFO reads are issued.
REQ-006 fEmpty  input  1  empty flag of the upstream bit FIFO.
REQ-007 fData  input  1  FIFO read data; it updates on the edge where fRdEn=1 and fEmpty=0, one-cycle read latency.
REQ-008 fRdEn  output  1  FIFO read enable, combinational from state and fEmpty.
REQ-009 iOut  output  8  signed in-phase sample, registered.
REQ-010 qOut  output  8  signed quadrature sample, registered.
REQ-011 symValid  output  1  high while iOut/qOut carry a mapped symbol, registered.
REQ-012 symStrobe  output  1  one-cycle pulse on the first cycle of each new symbol, registered.
REQ-013 underflow  output  1  one-cycle pulse per cycle spent stalled on an empty FIFO while en=1, registered.

Function
REQ-014 FSM states RD0, RD1, MAP and HOLD; reset state is RD0.
REQ-015 RD0: fRdEn = en & ~fEmpty; if fRdEn -> RD1, otherwise stay in RD0.
REQ-016 RD1: b0 <= fData every cycle; fRdEn = en & ~fEmpty; if fRdEn -> MAP, otherwise stay in RD1.
REQ-017 MAP: fRdEn=0; fData holds b1; at the edge, load iOut/qOut from (b0,b1), symValid<=1, symStrobe<=1, cnt<=SPS-4, -> HOLD.
REQ-018 HOLD: fRdEn=0; outputs held; cnt decrements; when cnt==0 -> RD0.
REQ-019 Steady-state symbol period (one symStrobe to the next) is exactly SPS cycles when the FIFO never runs empty.
REQ-020 Outputs stay held through HOLD, RD0, RD1 and MAP unless a stall occurs.
REQ-021 Stall: in RD0 or RD1 with en=1 and fEmpty=1, the edge drives iOut=qOut=0, symValid=0 and underflow=1; the state is unchanged.
REQ-022 en=0 in RD0 or RD1: no read and no state change; iOut=qOut=0, symValid=0, underflow=0.
REQ-023 en=0 in MAP or HOLD: the current symbol completes, then the FSM parks per REQ-022.
REQ-024 Direct mapping: bit 0 -> +AMP, bit 1 -> -AMP; b0 (first bit read) drives iOut and b1 drives qOut.
REQ-025 Bit order is preserved: b0 is the earlier FIFO bit.
REQ-026 A read is never issued when fEmpty=1.
REQ-027 Exactly two reads are issued per symbol.
REQ-028 symStrobe and underflow are low in every cycle not named above.

Reset
REQ-029 While RST=0: state=RD0, b0=0, cnt=0, iOut=qOut=0, symValid=0, symStrobe=0, underflow=0, phase=0.
REQ-030 Reset asserted mid-symbol aborts that symbol immediately; the partially fetched dibit is discarded.
REQ-031 fRdEn is 0 while RST=0.
REQ-032 Processing resumes at RD0 on the first edge after RST deasserts.

Configuration
REQ-033 Macro QPSK_DIFF_ENC_EN defined: DQPSK mode; 2-bit phase register.
REQ-034 DQPSK phase increment per dibit (b0b1): 00 -> +0, 01 -> +1, 11 -> +2, 10 -> +3, modulo 4, applied at MAP.
REQ-035 DQPSK output from the new phase: 0 -> (+AMP,+AMP), 1 -> (-AMP,+AMP), 2 -> (-AMP,-AMP), 3 -> (+AMP,-AMP).
REQ-036 Phase changes only in MAP and is cleared only by reset.
REQ-037 Macro QPSK_DIFF_ENC_EN undefined: direct mapping per REQ-024; no phase register is built.

Verification
REQ-038 FIFO preloaded 0,1 / SPS=4 / en=1 -> symStrobe 3 cycles after RST release; iOut=+90, qOut=-90; symValid=1.
REQ-039 Continuous bits 0,0,1,1,1,0 -> strobes exactly 4 cycles apart; (I,Q) = (+90,+90), (-90,-90), (-90,+90).
REQ-040 FIFO holds 1 bit, second bit arrives 5 cycles later -> 5 underflow pulses; I=Q=0 and symValid=0 during the stall; correct symbol after the stall.
REQ-041 RST pulsed low during HOLD -> all outputs 0 within the same cycle; fRdEn=0; the next symbol uses fresh bits.
REQ-042 QPSK_DIFF_ENC_EN defined, dibits 01,01,11 -> phases 1,2,0; (I,Q) = (-90,+90), (-90,-90), (+90,+90).
REQ-043 en=0 with a non-empty FIFO -> fRdEn never asserted; underflow=0; I=Q=0.

Source files
------------

// File: rtl/qpsk_symbol_mapper_if.sv
// Handshake and sample bundle between the bit FIFO, the QPSK mapper and its consumer.
// The mapper uses the slave modport; the FIFO/consumer side uses the master modport.
interface qpsk_symbol_mapper_if;
  logic              en;
  logic              fEmpty;
  logic              fData;
  logic              fRdEn;
  logic signed [7:0] iOut;
  logic signed [7:0] qOut;
  logic              symValid;
  logic              symStrobe;
  logic              underflow;

  modport master (
    output en, fEmpty, fData,
    input  fRdEn, iOut, qOut, symValid, symStrobe, underflow
  );

  modport slave (
    input  en, fEmpty, fData,
    output fRdEn, iOut, qOut, symValid, symStrobe, underflow
  );
endinterface

// File: rtl/qpsk_symbol_mapper.sv
// QPSK symbol mapper: fetches two bits per symbol from a FIFO and holds the I/Q pair for SPS cycles.
// Define QPSK_DIFF_ENC_EN to build the differential (DQPSK) variant with a 2-bit phase accumulator.
module qpsk_symbol_mapper #(
  parameter int unsigned       SPS = 4,
  parameter logic signed [7:0] AMP = 8'sd90
) (
  input logic                 CLK,
  input logic                 RST,
  qpsk_symbol_mapper_if.slave bus
);

  typedef enum logic [1:0] {
    RD0  = 2'd0,
    RD1  = 2'd1,
    MAP  = 2'd2,
    HOLD = 2'd3
  } state_t;

  // MAP and RD0/RD1 each take one cycle, so HOLD covers the remaining SPS-3 cycles.
  localparam logic [7:0] HOLD_LOAD = 8'(SPS - 32'd4);

  state_t            state_q, state_d;
  logic              b0_q, b0_d;
  logic [7:0]        cnt_q, cnt_d;
  logic signed [7:0] i_q, i_d;
  logic signed [7:0] q_q, q_d;
  logic              valid_q, valid_d;
  logic              strobe_q, strobe_d;
  logic              uflow_q, uflow_d;
  logic              rd_en_s;

`ifdef QPSK_DIFF_ENC_EN
  logic [1:0] phase_q, phase_d;

  // Gray-coded dibit to phase step: 00->0, 01->1, 11->2, 10->3.
  function automatic logic [1:0] phase_inc(input logic b0, input logic b1);
    return {b0, b0 ^ b1};
  endfunction

  function automatic logic signed [7:0] phase_i(input logic [1:0] ph);
    return (ph[1] ^ ph[0]) ? -AMP : AMP;
  endfunction

  function automatic logic signed [7:0] phase_q_rail(input logic [1:0] ph);
    return ph[1] ? -AMP : AMP;
  endfunction
`else
  function automatic logic signed [7:0] map_bit(input logic b);
    return b ? -AMP : AMP;
  endfunction
`endif

  assign bus.fRdEn     = RST & rd_en_s;
  assign bus.iOut      = i_q;
  assign bus.qOut      = q_q;
  assign bus.symValid  = valid_q;
  assign bus.symStrobe = strobe_q;
  assign bus.underflow = uflow_q;

  always_comb begin
    state_d  = state_q;
    b0_d     = b0_q;
    cnt_d    = cnt_q;
    i_d      = i_q;
    q_d      = q_q;
    valid_d  = valid_q;
    strobe_d = 1'b0;
    uflow_d  = 1'b0;
    rd_en_s  = 1'b0;
`ifdef QPSK_DIFF_ENC_EN
    phase_d  = phase_q;
`endif
    case (state_q)
      RD0, RD1: begin
        rd_en_s = bus.en & ~bus.fEmpty;
        if (state_q == RD1) begin
          b0_d = bus.fData;
        end else begin
          b0_d = b0_q;
        end
        if (rd_en_s) begin
          state_d = (state_q == RD0) ? RD1 : MAP;
        end else if (bus.en) begin
          // Starved while enabled: blank the outputs and flag the lost cycle.
          i_d     = 8'sd0;
          q_d     = 8'sd0;
          valid_d = 1'b0;
          uflow_d = 1'b1;
        end else begin
          i_d     = 8'sd0;
          q_d     = 8'sd0;
          valid_d = 1'b0;
        end
      end
      MAP: begin
`ifdef QPSK_DIFF_ENC_EN
        phase_d = phase_q + phase_inc(b0_q, bus.fData);
        i_d     = phase_i(phase_d);
        q_d     = phase_q_rail(phase_d);
`else
        i_d     = map_bit(b0_q);
        q_d     = map_bit(bus.fData);
`endif
        valid_d  = 1'b1;
        strobe_d = 1'b1;
        cnt_d    = HOLD_LOAD;
        state_d  = HOLD;
      end
      HOLD: begin
        if (cnt_q == 8'd0) begin
          state_d = RD0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = RD0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= RD0;
      b0_q     <= 1'b0;
      cnt_q    <= 8'd0;
      i_q      <= 8'sd0;
      q_q      <= 8'sd0;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
      uflow_q  <= 1'b0;
`ifdef QPSK_DIFF_ENC_EN
      phase_q  <= 2'd0;
`endif
    end else begin
      state_q  <= state_d;
      b0_q     <= b0_d;
      cnt_q    <= cnt_d;
      i_q      <= i_d;
      q_q      <= q_d;
      valid_q  <= valid_d;
      strobe_q <= strobe_d;
      uflow_q  <= uflow_d;
`ifdef QPSK_DIFF_ENC_EN
      phase_q  <= phase_d;
`endif
    end
  end

endmodule

// File: tb/tb_qpsk_symbol_mapper.sv
// Bench for qpsk_symbol_mapper: queue-based bit FIFO, randomized bit streams and a dibit-level
// reference model (direct or DQPSK depending on QPSK_DIFF_ENC_EN).
`timescale 1ns/1ps
module tb_qpsk_symbol_mapper;
  localparam int SPS = 4;
  localparam int AMP = 90;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  qpsk_symbol_mapper_if bus();

  qpsk_symbol_mapper #(.SPS(SPS), .AMP(8'sd90)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  bit fifo_q[$];
  int reads = 0;
  int bad_reads = 0;
  int ref_phase = 0;

  // FIFO model: read requested at a rising edge is delivered on fData before the next edge.
  initial begin
    bit rd;
    forever begin
      @(posedge CLK);
      rd = (bus.fRdEn === 1'b1);
      if (rd && bus.fEmpty) bad_reads++;
      if (rd) reads++;
      @(negedge CLK);
      if (rd && fifo_q.size() > 0) bus.fData = fifo_q.pop_front();
      bus.fEmpty = (fifo_q.size() == 0);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input bit b);
    fifo_q.push_back(b);
    bus.fEmpty = 1'b0;
  endtask

  task automatic apply_reset();
    RST = 1'b0;
    fifo_q.delete();
    bus.fEmpty = 1'b1;
    ref_phase = 0;
    repeat (2) tick();
  endtask

  // Expected (I,Q) for one dibit taken from the FIFO in order (b0 first).
  function automatic void model_sym(input bit b0, input bit b1, output int ei, output int eq);
`ifdef QPSK_DIFF_ENC_EN
    int inc;
    case ({b0, b1})
      2'b00:   inc = 0;
      2'b01:   inc = 1;
      2'b11:   inc = 2;
      default: inc = 3;
    endcase
    ref_phase = (ref_phase + inc) % 4;
    ei = (ref_phase == 0 || ref_phase == 3) ? AMP : -AMP;
    eq = (ref_phase <= 1) ? AMP : -AMP;
`else
    ei = b0 ? -AMP : AMP;
    eq = b1 ? -AMP : AMP;
`endif
  endfunction

  task automatic test_reset();
    apply_reset();
    bus.en = 1'b1;
    push(1'b0);
    push(1'b1);
    #1;
    checks++;
    if (bus.fRdEn !== 1'b0) begin
      errors++;
      $display("FAIL reset_fRdEn actual=%b required=0", bus.fRdEn);
    end
    checks++;
    if ({bus.iOut, bus.qOut, bus.symValid, bus.symStrobe, bus.underflow} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs actual I=%0d Q=%0d v=%b s=%b u=%b required all 0",
               $signed(bus.iOut), $signed(bus.qOut), bus.symValid, bus.symStrobe, bus.underflow);
    end
  endtask

  // FIFO already holds 0,1 from test_reset; strobe lands on the third edge after release.
  task automatic test_first_symbol();
    int ei, eq;
    model_sym(1'b0, 1'b1, ei, eq);
    RST = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++;
      if (bus.symStrobe !== (c == 3)) begin
        errors++;
        $display("FAIL first_strobe cycle=%0d actual=%b required=%b", c, bus.symStrobe, c == 3);
      end
    end
    checks++;
    if (bus.iOut !== 8'(ei) || bus.qOut !== 8'(eq) || bus.symValid !== 1'b1) begin
      errors++;
      $display("FAIL first_symbol actual I=%0d Q=%0d v=%b required I=%0d Q=%0d v=1",
               $signed(bus.iOut), $signed(bus.qOut), bus.symValid, ei, eq);
    end
  endtask

  task automatic test_stream();
    bit bits[$];
    int exp_i[$], exp_q[$];
    int ei, eq, k, last_c;
    apply_reset();
    bus.en = 1'b1;
    bits = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int n = 0; n < 20; n++) bits.push_back(1'($urandom_range(0, 1)));
    for (int n = 0; n < bits.size(); n += 2) begin
      model_sym(bits[n], bits[n+1], ei, eq);
      exp_i.push_back(ei);
      exp_q.push_back(eq);
    end
    foreach (bits[n]) push(bits[n]);
    RST = 1'b1;
    k = 0;
    last_c = 0;
    for (int c = 1; c <= exp_i.size() * SPS + 20 && k < exp_i.size(); c++) begin
      tick();
      if (bus.symStrobe === 1'b1) begin
        checks++;
        if (bus.iOut !== 8'(exp_i[k]) || bus.qOut !== 8'(exp_q[k]) || bus.symValid !== 1'b1) begin
          errors++;
          $display("FAIL stream_sym k=%0d actual I=%0d Q=%0d v=%b required I=%0d Q=%0d v=1",
                   k, $signed(bus.iOut), $signed(bus.qOut), bus.symValid, exp_i[k], exp_q[k]);
        end
        checks++;
        if (k > 0 && c - last_c != SPS) begin
          errors++;
          $display("FAIL stream_period k=%0d actual=%0d required=%0d", k, c - last_c, SPS);
        end
        last_c = c;
        k++;
      end else if (k > 0) begin
        checks++;
        if (bus.iOut !== 8'(exp_i[k-1]) || bus.qOut !== 8'(exp_q[k-1]) ||
            bus.symValid !== 1'b1 || bus.underflow !== 1'b0) begin
          errors++;
          $display("FAIL stream_hold cycle=%0d actual I=%0d Q=%0d v=%b u=%b required I=%0d Q=%0d v=1 u=0",
                   c, $signed(bus.iOut), $signed(bus.qOut), bus.symValid, bus.underflow,
                   exp_i[k-1], exp_q[k-1]);
        end
      end
    end
    checks++;
    if (k != exp_i.size()) begin
      errors++;
      $display("FAIL stream_count actual=%0d required=%0d", k, exp_i.size());
    end
  endtask

  task automatic test_underflow();
    int ei, eq, uf;
    bit got;
    apply_reset();
    bus.en = 1'b1;
    push(1'b1);
    model_sym(1'b1, 1'b0, ei, eq);
    RST = 1'b1;
    uf = 0;
    got = 1'b0;
    for (int c = 1; c <= 20 && !got; c++) begin
      tick();
      if (bus.underflow === 1'b1) begin
        uf++;
        checks++;
        if ({bus.iOut, bus.qOut, bus.symValid} !== 17'd0) begin
          errors++;
          $display("FAIL stall_outputs cycle=%0d actual I=%0d Q=%0d v=%b required 0 0 0",
                   c, $signed(bus.iOut), $signed(bus.qOut), bus.symValid);
        end
      end
      if (c == 6) push(1'b0);
      if (bus.symStrobe === 1'b1) got = 1'b1;
    end
    checks++;
    if (uf != 5) begin
      errors++;
      $display("FAIL underflow_count actual=%0d required=5", uf);
    end
    checks++;
    if (!got || bus.iOut !== 8'(ei) || bus.qOut !== 8'(eq) || bus.symValid !== 1'b1) begin
      errors++;
      $display("FAIL after_stall_symbol actual strobe=%b I=%0d Q=%0d v=%b required strobe=1 I=%0d Q=%0d v=1",
               got, $signed(bus.iOut), $signed(bus.qOut), bus.symValid, ei, eq);
    end
  endtask

  task automatic test_reset_mid();
    bit b[7];
    int ei, eq;
    apply_reset();
    bus.en = 1'b1;
    foreach (b[n]) b[n] = 1'($urandom_range(0, 1));
    b[4] = ~b[6];
    foreach (b[n]) push(b[n]);
    RST = 1'b1;
    repeat (3) tick();
    // Now in HOLD with the first symbol on the outputs.
    RST = 1'b0;
    ref_phase = 0;
    #1;
    checks++;
    if ({bus.iOut, bus.qOut, bus.symValid, bus.symStrobe, bus.underflow, bus.fRdEn} !== 20'd0) begin
      errors++;
      $display("FAIL hold_reset actual I=%0d Q=%0d v=%b s=%b u=%b rd=%b required all 0",
               $signed(bus.iOut), $signed(bus.qOut), bus.symValid, bus.symStrobe,
               bus.underflow, bus.fRdEn);
    end
    tick();
    RST = 1'b1;
    model_sym(b[2], b[3], ei, eq);
    repeat (3) tick();
    checks++;
    if (bus.symStrobe !== 1'b1 || bus.iOut !== 8'(ei) || bus.qOut !== 8'(eq)) begin
      errors++;
      $display("FAIL post_reset_symbol actual s=%b I=%0d Q=%0d required s=1 I=%0d Q=%0d",
               bus.symStrobe, $signed(bus.iOut), $signed(bus.qOut), ei, eq);
    end
    repeat (2) tick();
    // Now in RD1 holding b[4]; reset must discard it.
    RST = 1'b0;
    ref_phase = 0;
    tick();
    RST = 1'b1;
    model_sym(b[5], b[6], ei, eq);
    repeat (3) tick();
    checks++;
    if (bus.symStrobe !== 1'b1 || bus.iOut !== 8'(ei) || bus.qOut !== 8'(eq)) begin
      errors++;
      $display("FAIL discard_partial actual s=%b I=%0d Q=%0d required s=1 I=%0d Q=%0d",
               bus.symStrobe, $signed(bus.iOut), $signed(bus.qOut), ei, eq);
    end
  endtask

  task automatic test_disable();
    int ei, eq, rd0;
    apply_reset();
    bus.en = 1'b0;
    for (int n = 0; n < 4; n++) push(1'($urandom_range(0, 1)));
    rd0 = reads;
    RST = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      checks++;
      if (bus.fRdEn !== 1'b0 || bus.underflow !== 1'b0 || {bus.iOut, bus.qOut, bus.symValid} !== 17'd0) begin
        errors++;
        $display("FAIL disabled cycle=%0d actual rd=%b u=%b I=%0d Q=%0d v=%b required 0",
                 c, bus.fRdEn, bus.underflow, $signed(bus.iOut), $signed(bus.qOut), bus.symValid);
      end
    end
    checks++;
    if (reads != rd0) begin
      errors++;
      $display("FAIL disabled_reads actual=%0d required=%0d", reads - rd0, 0);
    end
    model_sym(fifo_q[0], fifo_q[1], ei, eq);
    bus.en = 1'b1;
    repeat (3) tick();
    checks++;
    if (bus.symStrobe !== 1'b1 || bus.iOut !== 8'(ei) || bus.qOut !== 8'(eq)) begin
      errors++;
      $display("FAIL enable_symbol actual s=%b I=%0d Q=%0d required s=1 I=%0d Q=%0d",
               bus.symStrobe, $signed(bus.iOut), $signed(bus.qOut), ei, eq);
    end
    // Drop enable in HOLD: the symbol finishes, then the mapper parks without reading.
    bus.en = 1'b0;
    rd0 = reads;
    tick();
    checks++;
    if (bus.symValid !== 1'b1 || bus.iOut !== 8'(ei)) begin
      errors++;
      $display("FAIL hold_complete actual v=%b I=%0d required v=1 I=%0d",
               bus.symValid, $signed(bus.iOut), ei);
    end
    repeat (6) tick();
    checks++;
    if (reads != rd0 || bus.symValid !== 1'b0 || bus.underflow !== 1'b0) begin
      errors++;
      $display("FAIL park actual reads=%0d v=%b u=%b required reads=0 v=0 u=0",
               reads - rd0, bus.symValid, bus.underflow);
    end
  endtask

  initial begin
    bus.en = 1'b0;
    bus.fEmpty = 1'b1;
    bus.fData = 1'b0;
    test_reset();
    test_first_symbol();
    test_stream();
    test_underflow();
    test_reset_mid();
    test_disable();
    checks++;
    if (bad_reads != 0) begin
      errors++;
      $display("FAIL read_when_empty actual=%0d required=0", bad_reads);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
